// File: rtl/park_pkg.sv
// Shared definitions for the Park / inverse Park transform blocks:
// FSM states, MAC op codes, and the width/rounding/saturation helpers.
package park_pkg;

    // Helpers work at a fixed maximum width and are narrowed by the caller.
    localparam int MAX_W   = 64;
    localparam int ACC_MAX = 2 * MAX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        A0,
        A1,
        B0,
        B1,
        OUT
    } park_state_t;

    typedef enum logic [1:0] {
        MAC_LOAD,
        MAC_ADD,
        MAC_SUB
    } mac_op_t;

    typedef struct packed {
        logic signed [MAX_W-1:0] value;
        logic                    flag;
    } sat_res_t;

    // Two full products plus one guard bit, so their sum or difference never overflows.
    function automatic int acc_width(input int w);
        return 2 * w + 1;
    endfunction

    function automatic logic signed [ACC_MAX-1:0] round_const(input int q_bits);
        return ACC_MAX'(1) <<< (q_bits - 1);
    endfunction

    // Clamps v to the signed w-bit range when en is set; otherwise the low bits
    // pass through, which wraps once the caller keeps only w of them.
    function automatic sat_res_t saturate(input logic signed [ACC_MAX-1:0] v,
                                          input int                        w,
                                          input logic                      en);
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        sat_res_t                  r;
        hi      = (ACC_MAX'(1) <<< (w - 1)) - ACC_MAX'(1);
        lo      = ~hi;
        r.value = v[MAX_W-1:0];
        r.flag  = 1'b0;
        if (en && (v > hi)) begin
            r.value = hi[MAX_W-1:0];
            r.flag  = 1'b1;
        end else if (en && (v < lo)) begin
            r.value = lo[MAX_W-1:0];
            r.flag  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/park_mac.sv
// Shared signed multiply-accumulate: load, add or subtract one product per enabled cycle.
// acc_d is the value the accumulator takes at the coming edge, so callers can round it in the same cycle.
module park_mac
    import park_pkg::*;
#(
    parameter int W     = 32,
    parameter int ACC_W = 2 * W + 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    en,
    input  logic [1:0]              op,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc_d
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] acc;

    // Operands widened first so (-2^(W-1))^2 is exact.
    assign prod   = (2 * W)'(a) * (2 * W)'(b);
    assign prod_x = ACC_W'(prod);

    always_comb begin
        // NOTE: acc_d gets a default before the case so no latch is inferred for unlisted ops.
        acc_d = acc;
        if (en) begin
            case (mac_op_t'(op))
                MAC_LOAD: acc_d = prod_x;
                MAC_ADD:  acc_d = acc + prod_x;
                MAC_SUB:  acc_d = acc - prod_x;
                default:  acc_d = acc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc <= '0;
        end else begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/inverse_park_seq.sv
// Inverse Park transform: alpha = cos*D - sin*Q, beta = sin*D + cos*Q, computed over
// four cycles on one shared multiplier with rounding, optional saturation and handshakes.
module inverse_park_seq
    import park_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10,
    parameter int ROUND   = 1,
    parameter int SAT     = 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [D_WIDTH-1:0] d_in,
    input  logic signed [D_WIDTH-1:0] q_in,
    input  logic signed [D_WIDTH-1:0] sin_in,
    input  logic signed [D_WIDTH-1:0] cos_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_WIDTH-1:0] alpha,
    output logic signed [D_WIDTH-1:0] beta,
    output logic                      sat
);

    localparam int ACC_W = acc_width(D_WIDTH);
    localparam logic signed [ACC_W-1:0] RND_K =
        (ROUND != 0) ? ACC_W'(round_const(Q_BITS)) : '0;

    park_state_t state;
    park_state_t state_n;

    logic signed [D_WIDTH-1:0] d_r;
    logic signed [D_WIDTH-1:0] q_r;
    logic signed [D_WIDTH-1:0] s_r;
    logic signed [D_WIDTH-1:0] c_r;

    logic                      mac_en;
    mac_op_t                   mac_op;
    logic signed [D_WIDTH-1:0] mac_a;
    logic signed [D_WIDTH-1:0] mac_b;
    logic signed [ACC_W-1:0]   acc_d;

    logic signed [ACC_W-1:0]   acc_rnd;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [ACC_MAX-1:0] acc_ext;
    sat_res_t                  res;
    logic                      accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = A0;
            A0:      state_n = A1;
            A1:      state_n = B0;
            B0:      state_n = B1;
            B1:      state_n = OUT;
            OUT:     if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand schedule: A0 cos*D, A1 -sin*Q, B0 sin*D, B1 +cos*Q.
    always_comb begin
        mac_en = 1'b0;
        mac_op = MAC_LOAD;
        mac_a  = c_r;
        mac_b  = d_r;
        case (state)
            A0: mac_en = 1'b1;
            A1: begin
                mac_en = 1'b1;
                mac_op = MAC_SUB;
                mac_a  = s_r;
                mac_b  = q_r;
            end
            B0: begin
                mac_en = 1'b1;
                mac_a  = s_r;
            end
            B1: begin
                mac_en = 1'b1;
                mac_op = MAC_ADD;
                mac_b  = q_r;
            end
            default: mac_en = 1'b0;
        endcase
    end

    park_mac #(
        .W     (D_WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rstb  (rstb),
        .en    (mac_en),
        .op    (mac_op),
        .a     (mac_a),
        .b     (mac_b),
        .acc_d (acc_d)
    );

    // Arithmetic shift floors, so adding half an LSB first gives round-half-up.
    assign acc_rnd = acc_d + RND_K;
    assign acc_shr = acc_rnd >>> Q_BITS;
    assign acc_ext = ACC_MAX'(acc_shr);
    assign res     = saturate(acc_ext, D_WIDTH, SAT != 0);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            alpha     <= '0;
            beta      <= '0;
            sat       <= 1'b0;
            d_r       <= '0;
            q_r       <= '0;
            s_r       <= '0;
            c_r       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_n;
            in_ready <= (state_n == IDLE);
            if (accept) begin
                d_r <= d_in;
                q_r <= q_in;
                s_r <= sin_in;
                c_r <= cos_in;
                sat <= 1'b0;
            end
            if (state == A1) begin
                alpha <= res.value[D_WIDTH-1:0];
                sat   <= res.flag;
            end
            if (state == B1) begin
                beta      <= res.value[D_WIDTH-1:0];
                sat       <= sat | res.flag;
                out_valid <= 1'b1;
            end
            if ((state == OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/inverse_park_seq.md
Name: inverse_park_seq

Overview:
Parametrised inverse Park transform: rotates a (D, Q) vector by a sin/cos pair into stationary-frame (alpha, beta).
- alpha = cos·D − sin·Q
- beta = sin·D + cos·Q
- One shared signed multiplier, time-multiplexed by an FSM.
- Selectable rounding, output saturation with a flag, and valid/ready handshakes on both sides.
- Sits between the current controller (D/Q outputs) and the SVPWM/modulator stage.

Parameters:
- D_WIDTH, 32: width of D, Q, sin, cos, alpha, beta (signed two's complement).
- Q_BITS, 10: fractional bits of sin/cos; 1.0 = 2^Q_BITS. Legal range 1..D_WIDTH-2.
- ROUND, 1: 1 = round-half-up before shift; 0 = truncate (arithmetic floor).
- SAT, 1: 1 = clamp results to D_WIDTH signed range; 0 = wrap (keep low D_WIDTH bits).

Ports:
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept operands
- d_in  in  D_WIDTH  direct-axis value, signed
- q_in  in  D_WIDTH  quadrature-axis value, signed
- sin_in  in  D_WIDTH  sin(theta), signed Q_BITS fixed point
- cos_in  in  D_WIDTH  cos(theta), signed Q_BITS fixed point
- out_valid  out  1  alpha/beta valid
- out_ready  in  1  downstream accepts result
- alpha  out  D_WIDTH  result, signed
- beta  out  D_WIDTH  result, signed
- sat  out  1  alpha or beta was clamped (SAT=1 only; tied 0 when SAT=0)

Behaviour:
- Reset (rstb low, async): state IDLE; in_ready=0 during reset; out_valid=0, alpha=0, beta=0, sat=0; accumulator and operand registers cleared.
- in_ready = 1 only in IDLE with rstb deasserted (registered state decode, no combinational path from out_ready).
- Accept: edge where in_valid && in_ready. d/q/sin/cos are captured into operand registers. Inputs are ignored at all other times.
- FSM states: IDLE -> A0 -> A1 -> B0 -> B1 -> OUT -> IDLE.
  - A0: acc = cos·D
  - A1: acc = acc − sin·Q; alpha_r <= shift/round/sat(acc)
  - B0: acc = sin·D
  - B1: acc = acc + cos·Q; beta_r <= shift/round/sat(acc); out_valid set at this edge.
  - OUT: alpha, beta and sat are held stable while out_valid && !out_ready. The edge with out_ready=1 clears out_valid and returns to IDLE.
- Latency: accept at edge T; out_valid high from edge T+4.
- Minimum initiation interval is 6 cycles. There is no overlap: a new accept cannot occur in the same cycle as the output handshake.
- Arithmetic:
  - Product width 2·D_WIDTH; accumulator width 2·D_WIDTH+1, so the sum of two products never overflows.
  - ROUND=1: add 2^(Q_BITS-1) to acc, then arithmetic shift right by Q_BITS.
  - ROUND=0: arithmetic shift right only (e.g. −1.5 → −2).
- Saturation (SAT=1): a shifted value above 2^(D_WIDTH-1)−1 becomes the max; below −2^(D_WIDTH-1) becomes the min.
  - sat = OR of alpha-clamped and beta-clamped for the current result.
  - sat is cleared on the next accept.
- Boundary conditions:
  - in_valid asserted during busy states: no effect, no capture.
  - out_ready high while out_valid is low: no effect.
  - rstb asserted mid-operation (any state): immediate abort to reset values; the partial result is discarded and never presented.
  - sin = cos = 0: alpha = beta = 0, sat = 0.
  - Extreme negatives (−2^(D_WIDTH-1) × −2^(D_WIDTH-1)) must be exact in the accumulator.

Decomposition:
- Shared package park_pkg:
  - FSM state enum (IDLE, A0, A1, B0, B1, OUT).
  - Function for the accumulator width (2·D_WIDTH+1).
  - Rounding-constant function 2^(Q_BITS-1).
  - Saturate function returning {clamped value, flag}; shared with the future forward Park block.
- Sub-module park_mac: registered signed multiply with load/add/subtract op select and acc output. The FSM drives operand muxing and the op code.

Test Plan:
- D_WIDTH=32, Q_BITS=10, cos=1024, sin=0, D=500, Q=−300 -> alpha=500, beta=−300, sat=0, out_valid exactly 4 cycles after accept.
- sin=1024, cos=0, D=100, Q=50 -> alpha=−50, beta=100. Then back-to-back in_valid held high -> second accept no earlier than 6 cycles after the first.
- cos=512, sin=0, D=3, Q=0 -> ROUND=1: alpha=2; ROUND=0: alpha=1; beta=0. D=−3 -> ROUND=1: −1; ROUND=0: −2.
- D_WIDTH=16, Q_BITS=10, SAT=1, cos=sin=1024, D=32767, Q=−32768 -> alpha=32767 (clamped), beta=−1, sat=1. Same stimulus with SAT=0 -> alpha=−1 (wrapped), sat=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> alpha/beta/sat stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rstb low during B0 -> out_valid, alpha, beta, sat = 0 immediately. After release, a fresh accept yields a correct result with no trace of the aborted one.
